reg_write_arbiter: RTL

- Shares one 4-bit enabled register (clk, reset, en, d → q) between up to NUM_REQ requesters.
- Arbitrates write requests, latches the winning requester's data, and pulses the register's enable for exactly one cycle.
- Returns a one-cycle acknowledge to the winner once the register holds the new value.
- Sits between requester blocks and the register instance; its reg_en/reg_d drive the register's en/d.

---
 rtl/reg_arb_pkg.sv | 13 +
 rtl/reg_write_arbiter_rr_pick.sv | 27 ++
 rtl/reg_write_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/reg_arb_pkg.sv
// rtl/reg_arb_pkg.sv - shared state encoding and default sizes for reg_write_arbiter
package reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_e;

  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 4;

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// rtl/reg_write_arbiter_rr_pick.sv - combinational winner select, searching from start and wrapping
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

  // Walk from farthest to nearest so the requester closest to start overwrites.
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    valid  = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(start) + k) % N;
      if (req[idx]) begin
        winner = IDX_W'(idx);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - arbitrates requester writes into one enabled register
// REG_ARB_RR_EN selects round-robin; otherwise fixed priority with index 0 highest.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int  NUM_REQ = NUM_REQ_DEF,
  parameter int  DATA_W  = DATA_W_DEF,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      reg_en,
  output logic [DATA_W-1:0]         reg_d,
  output logic [IDX_W-1:0]          gnt_id,
  output logic                      busy
);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               reg_en_q, reg_en_d;
  logic [DATA_W-1:0]  reg_d_q, reg_d_d;
  logic [IDX_W-1:0]   gnt_id_q, gnt_id_d;
  logic               busy_q, busy_d;
  logic [IDX_W-1:0]   start;
  logic [IDX_W-1:0]   winner;
  logic               win_valid;

`ifdef REG_ARB_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;
  assign start = ptr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end
`else
  assign start = '0;
`endif

  rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req    (req),
    .start  (start),
    .winner (winner),
    .valid  (win_valid)
  );

  always_comb begin
    state_d  = state_q;
    ack_d    = '0;
    reg_en_d = 1'b0;
    reg_d_d  = reg_d_q;
    gnt_id_d = gnt_id_q;
`ifdef REG_ARB_RR_EN
    ptr_d    = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d  = WRITE;
          reg_d_d  = wdata[int'(winner)*DATA_W +: DATA_W];
          gnt_id_d = winner;
          reg_en_d = 1'b1;
        end
      end
      WRITE: begin
        state_d         = ACK;
        ack_d[gnt_id_q] = 1'b1;
      end
      ACK: begin
        state_d = IDLE;
`ifdef REG_ARB_RR_EN
        ptr_d = (gnt_id_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_id_q + 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ack_q    <= '0;
      reg_en_q <= 1'b0;
      reg_d_q  <= '0;
      gnt_id_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      reg_en_q <= reg_en_d;
      reg_d_q  <= reg_d_d;
      gnt_id_q <= gnt_id_d;
      busy_q   <= busy_d;
    end
  end

  assign ack    = ack_q;
  assign reg_en = reg_en_q;
  assign reg_d  = reg_d_q;
  assign gnt_id = gnt_id_q;
  assign busy   = busy_q;

endmodule
